// File: rtl/fetch_queue_pkg.sv
// Shared types and default parameters for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH   = 8;
  localparam int unsigned FQ_POP_N   = 2;
  localparam int unsigned FQ_MAX_OUT = 4;
  localparam int unsigned FQ_PC_W    = 32;
  localparam int unsigned FQ_INSTR_W = 32;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch request/response and decode-side dequeue bundle of the fetch queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = FQ_DEPTH,
  parameter int unsigned POP_N   = FQ_POP_N,
  parameter int unsigned PC_W    = FQ_PC_W,
  parameter int unsigned INSTR_W = FQ_INSTR_W
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned DEQ_W = $clog2(POP_N + 1);

  logic                       req_valid;
  logic                       req_ready;
  logic                       resp_valid;
  logic [PC_W-1:0]            resp_pc;
  logic [INSTR_W-1:0]         resp_instr;
  logic [POP_N-1:0]           out_valid;
  logic [POP_N*PC_W-1:0]      out_pc;
  logic [POP_N*INSTR_W-1:0]   out_instr;
  logic [DEQ_W-1:0]           deq_num;
  logic [CNT_W-1:0]           count;

  // Fetch/decode side
  modport master (
    output req_valid, resp_valid, resp_pc, resp_instr, deq_num,
    input  req_ready, out_valid, out_pc, out_instr, count
  );

  // Queue side
  modport slave (
    input  req_valid, resp_valid, resp_pc, resp_instr, deq_num,
    output req_ready, out_valid, out_pc, out_instr, count
  );

endinterface

// File: rtl/fetch_queue_counter.sv
// Up/down counter with synchronous load, used for outstanding and drop tracking.
module fq_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else begin
      value <= value + W'(inc) - W'(dec);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode; drops responses owed to pre-redirect requests.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = FQ_DEPTH,
  parameter int unsigned POP_N   = FQ_POP_N,
  parameter int unsigned MAX_OUT = FQ_MAX_OUT,
  parameter int unsigned PC_W    = FQ_PC_W,
  parameter int unsigned INSTR_W = FQ_INSTR_W
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  fetch_queue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [OUT_W-1:0]   outstanding;
  logic [OUT_W-1:0]   drop_cnt;
  logic [OCC_W-1:0]   occupancy;
  logic               req_fire;
  logic               push;
  logic               drop;
  logic               ready_c;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [POP_N-1:0]         slot_valid;
  logic [POP_N*PC_W-1:0]    slot_pc;
  logic [POP_N*INSTR_W-1:0] slot_instr;

  // Slots already promised to in-flight, non-stale requests count against capacity.
  assign occupancy = OCC_W'(count) + OCC_W'(outstanding) - OCC_W'(drop_cnt);
  assign ready_c   = !flush && (outstanding < OUT_W'(MAX_OUT)) && (occupancy < OCC_W'(DEPTH));
  assign req_fire  = bus.req_valid && ready_c;
  assign push      = bus.resp_valid && (drop_cnt == '0) && !flush;
  assign drop      = bus.resp_valid && (drop_cnt != '0);
  assign count_next = count + CNT_W'(push) - CNT_W'(bus.deq_num);

  fq_counter #(.W(OUT_W)) u_outstanding (
    .clk      (clk),
    .rst_n    (resetn),
    .load     (1'b0),
    .load_val ('0),
    .inc      (req_fire),
    .dec      (bus.resp_valid),
    .value    (outstanding)
  );

  // On redirect, every response still owed (except one arriving now) becomes stale.
  fq_counter #(.W(OUT_W)) u_drop_cnt (
    .clk      (clk),
    .rst_n    (resetn),
    .load     (flush),
    .load_val (outstanding - OUT_W'(bus.resp_valid)),
    .inc      (1'b0),
    .dec      (drop),
    .value    (drop_cnt)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      head  <= head + PTR_W'(bus.deq_num);
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]    <= bus.resp_pc;
      instr_mem[tail] <= bus.resp_instr;
    end
  end

  // Zero-latency read of the POP_N oldest entries.
  always_comb begin
    slot_valid = '0;
    slot_pc    = '0;
    slot_instr = '0;
    for (int unsigned k = 0; k < POP_N; k++) begin
      slot_valid[k]                       = count > CNT_W'(k);
      slot_pc[k*PC_W +: PC_W]             = pc_mem[head + PTR_W'(k)];
      slot_instr[k*INSTR_W +: INSTR_W]    = instr_mem[head + PTR_W'(k)];
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.out_valid = slot_valid;
  assign bus.out_pc    = slot_pc;
  assign bus.out_instr = slot_instr;
  assign bus.count     = count;

  a_resp_owed: assert property (@(posedge clk) disable iff (!resetn)
    bus.resp_valid |-> (outstanding != '0));

  a_deq_legal: assert property (@(posedge clk) disable iff (!resetn)
    CNT_W'(bus.deq_num) <= count);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned POP_N   = 2;
  localparam int unsigned MAX_OUT = 4;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic resetn;
  logic flush;

  fetch_queue_if #(.DEPTH(DEPTH), .POP_N(POP_N), .PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_queue #(
    .DEPTH(DEPTH), .POP_N(POP_N), .MAX_OUT(MAX_OUT), .PC_W(PC_W), .INSTR_W(INSTR_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: decoded queue, memory-side pending responses, owed/stale counts.
  fetch_entry_t mq[$];
  fetch_entry_t mem_q[$];
  int           outst;
  int           drop;
  logic [31:0]  next_pc;
  int           n_checks;
  int           n_fail;

  task automatic model_clear();
    mq.delete();
    mem_q.delete();
    outst = 0;
    drop  = 0;
  endtask

  task automatic idle_inputs();
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_pc    = '0;
    bus.resp_instr = '0;
    bus.deq_num    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // One clock: drive, compare DUT outputs with the model, then advance the model.
  task automatic step(input bit fl, input bit rv, input bit rsp, input int dq);
    fetch_entry_t r;
    bit           do_rsp;
    bit           exp_ready;
    bit           fire;
    int           d;
    logic [POP_N-1:0] ev;
    @(negedge clk);
    do_rsp = rsp && (mem_q.size() > 0);
    d = (dq > mq.size()) ? mq.size() : dq;
    if (do_rsp) r = mem_q[0];
    else begin
      r.pc    = $urandom;
      r.instr = $urandom;
    end
    flush          = fl;
    bus.req_valid  = rv;
    bus.resp_valid = do_rsp;
    bus.resp_pc    = r.pc;
    bus.resp_instr = r.instr;
    bus.deq_num    = 2'(d);
    #1;
    exp_ready = !fl && (outst < MAX_OUT) && ((mq.size() + outst - drop) < DEPTH);
    n_checks++;
    if (bus.count !== CNT_W'(mq.size())) begin
      n_fail++;
      $display("FAIL count: got %0d expected %0d", bus.count, mq.size());
    end
    for (int k = 0; k < POP_N; k++) ev[k] = (mq.size() > k);
    n_checks++;
    if (bus.out_valid !== ev) begin
      n_fail++;
      $display("FAIL out_valid: got %b expected %b", bus.out_valid, ev);
    end
    for (int k = 0; k < POP_N; k++) begin
      if (k < mq.size()) begin
        n_checks++;
        if (bus.out_pc[k*PC_W +: PC_W] !== mq[k].pc ||
            bus.out_instr[k*INSTR_W +: INSTR_W] !== mq[k].instr) begin
          n_fail++;
          $display("FAIL slot%0d: got pc %h instr %h expected pc %h instr %h", k,
                   bus.out_pc[k*PC_W +: PC_W], bus.out_instr[k*INSTR_W +: INSTR_W],
                   mq[k].pc, mq[k].instr);
        end
      end
    end
    n_checks++;
    if (bus.req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL req_ready: got %b expected %b", bus.req_ready, exp_ready);
    end
    @(posedge clk);
    fire = rv && exp_ready;
    if (do_rsp) void'(mem_q.pop_front());
    if (fl) begin
      mq.delete();
      drop = outst - int'(do_rsp);
    end else begin
      for (int i = 0; i < d; i++) void'(mq.pop_front());
      if (do_rsp) begin
        if (drop > 0) drop--;
        else mq.push_back(r);
      end
    end
    outst = outst + int'(fire) - int'(do_rsp);
    if (fire) begin
      mem_q.push_back('{pc: next_pc, instr: $urandom});
      next_pc = next_pc + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (bus.count !== '0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    n_checks++;
    if (bus.out_valid !== '0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 00", bus.out_valid);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_push3();
    do_reset();
    next_pc = 32'hBFC0_0000;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    n_checks++;
    if (bus.count !== CNT_W'(3) || bus.out_valid !== 2'b11 ||
        bus.out_pc[31:0] !== 32'hBFC0_0000 || bus.out_pc[63:32] !== 32'hBFC0_0004) begin
      n_fail++;
      $display("FAIL push3: got count %0d valid %b pc0 %h pc1 %h expected 3 11 bfc00000 bfc00004",
               bus.count, bus.out_valid, bus.out_pc[31:0], bus.out_pc[63:32]);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_fill();
    int guard;
    do_reset();
    next_pc = 32'h0000_1000;
    guard = 0;
    while ((mq.size() + outst) < DEPTH && guard < 64) begin
      step(0, 1, $urandom_range(0, 1) == 1, 0);
      guard++;
    end
    while (outst > 0 && guard < 64) begin
      step(0, 0, 1, 0);
      guard++;
    end
    n_checks++;
    if (guard >= 64 || bus.count !== CNT_W'(DEPTH) || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got count %0d ready %b guard %0d expected 8 0", bus.count,
               bus.req_ready, guard);
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 2);
    n_checks++;
    if (bus.count !== CNT_W'(6) || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_pop2: got count %0d ready %b expected 6 1", bus.count, bus.req_ready);
    end
  endtask

  task automatic test_dual_pop();
    int guard;
    logic [31:0] end_pc;
    do_reset();
    next_pc = 32'h0000_2000;
    end_pc  = 32'h0000_2000 + 32'd80;
    guard = 0;
    while ((next_pc != end_pc || mem_q.size() > 0 || mq.size() > 0) && guard < 200) begin
      step(0, next_pc != end_pc, 1, (mq.size() >= 2) ? 2 : ((next_pc == end_pc) ? 1 : 0));
      guard++;
    end
    n_checks++;
    if (guard >= 200 || bus.count !== '0) begin
      n_fail++;
      $display("FAIL dual_pop_drain: got count %0d guard %0d expected 0", bus.count, guard);
    end
  endtask

  task automatic test_flush_drop();
    do_reset();
    next_pc = 32'h0000_3000;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    next_pc = 32'hBFC0_0100;
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    n_checks++;
    if (bus.count !== '0) begin
      n_fail++; $display("FAIL flush_drop_stale: got count %0d expected 0", bus.count);
    end
    step(0, 0, 1, 0);
    n_checks++;
    if (bus.count !== CNT_W'(1) || bus.out_valid !== 2'b01 || bus.out_pc[31:0] !== 32'hBFC0_0100) begin
      n_fail++;
      $display("FAIL flush_drop_new: got count %0d valid %b pc %h expected 1 01 bfc00100",
               bus.count, bus.out_valid, bus.out_pc[31:0]);
    end
  endtask

  task automatic test_flush_with_resp();
    do_reset();
    next_pc = 32'h0000_4000;
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    n_checks++;
    if (bus.count !== '0) begin
      n_fail++; $display("FAIL flush_resp_drop: got count %0d expected 0", bus.count);
    end
    next_pc = 32'h0000_4100;
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    n_checks++;
    if (bus.count !== CNT_W'(1) || bus.out_pc[31:0] !== 32'h0000_4100) begin
      n_fail++;
      $display("FAIL flush_resp_new: got count %0d pc %h expected 1 00004100", bus.count,
               bus.out_pc[31:0]);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    next_pc = 32'h0000_5000;
    guard = 0;
    while ((mq.size() < 5 || outst < 2) && guard < 64) begin
      step(0, (mq.size() + outst) < 7, mq.size() < 5, 0);
      guard++;
    end
    n_checks++;
    if (guard >= 64 || bus.count !== CNT_W'(5)) begin
      n_fail++; $display("FAIL async_setup: got count %0d guard %0d expected 5", bus.count, guard);
    end
    @(negedge clk);
    idle_inputs();
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.count !== '0 || bus.out_valid !== '0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got count %0d valid %b ready %b expected 0 00 1", bus.count,
               bus.out_valid, bus.req_ready);
    end
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    next_pc = 32'h8000_0000;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    next_pc  = '0;
    model_clear();
    test_reset();
    test_push3();
    test_fill();
    test_dual_pop();
    test_flush_drop();
    test_flush_with_resp();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
